// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: debounced push-button steps through four LED blink
// patterns (OFF, SLOW, FAST, HEARTBEAT).
// The pattern is timed by a prescaled tick and a per-mode phase counter.
// led and mode are registered outputs.
module led_pattern_sequencer #(
    parameter int TICK_DIV  = 2700000,
    parameter int DB_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       led,
    output logic [1:0] mode
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DB_W   = $clog2(DB_CYCLES);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SLOW  = 2'd1,
        MODE_FAST  = 2'd2,
        MODE_HEART = 2'd3
    } mode_t;

    // Last phase index before wrapping back to 0 for each mode.
    function automatic logic [4:0] period_last(input mode_t m);
        case (m)
            MODE_OFF:   period_last = 5'd0;
            MODE_SLOW:  period_last = 5'd19;
            MODE_FAST:  period_last = 5'd3;
            MODE_HEART: period_last = 5'd9;
            default:    period_last = 5'd0;
        endcase
    endfunction

    // LED level for a given mode and phase.
    function automatic logic pattern_on(input mode_t m, input logic [4:0] ph);
        case (m)
            MODE_OFF:   pattern_on = 1'b0;
            MODE_SLOW:  pattern_on = (ph < 5'd10);
            MODE_FAST:  pattern_on = (ph < 5'd2);
            MODE_HEART: pattern_on = (ph == 5'd0) || (ph == 5'd2);
            default:    pattern_on = 1'b0;
        endcase
    endfunction

    // Mode order on each accepted press; wraps from HEARTBEAT back to OFF.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:   next_mode = MODE_SLOW;
            MODE_SLOW:  next_mode = MODE_FAST;
            MODE_FAST:  next_mode = MODE_HEART;
            MODE_HEART: next_mode = MODE_OFF;
            default:    next_mode = MODE_OFF;
        endcase
    endfunction

    logic              sync1_r;
    logic              btn_s;
    logic              db_state_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [4:0]        phase_r;
    mode_t             mode_r;
    logic              led_r;

    logic              db_state_s;
    logic [DB_W-1:0]   db_cnt_s;
    logic [TICK_W-1:0] tick_cnt_s;
    logic [4:0]        phase_s;
    mode_t             mode_s;
    logic              led_s;
    logic              press_s;
    logic              tick_s;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            sync1_r <= btn;
            btn_s   <= sync1_r;
        end
    end

    // Debounce, press detection, prescaler, phase and LED next-state logic.
    always_comb begin
        db_state_s = db_state_r;
        db_cnt_s   = db_cnt_r;
        tick_cnt_s = tick_cnt_r;
        phase_s    = phase_r;
        mode_s     = mode_r;
        press_s    = 1'b0;
        tick_s     = (tick_cnt_r == TICK_LAST);
        led_s      = pattern_on(mode_r, phase_r);

        // A level is accepted only after DB_CYCLES consecutive differing samples.
        if (btn_s == db_state_r) begin
            db_cnt_s = {DB_W{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
            db_state_s = btn_s;
            db_cnt_s   = {DB_W{1'b0}};
            press_s    = btn_s;
        end else begin
            db_cnt_s = db_cnt_r + DB_W'(1'b1);
        end

        // A press restarts the pattern and takes priority over a coincident tick.
        if (press_s) begin
            mode_s     = next_mode(mode_r);
            tick_cnt_s = {TICK_W{1'b0}};
            phase_s    = 5'd0;
        end else if (tick_s) begin
            tick_cnt_s = {TICK_W{1'b0}};
            if (phase_r >= period_last(mode_r)) begin
                phase_s = 5'd0;
            end else begin
                phase_s = phase_r + 5'd1;
            end
        end else begin
            tick_cnt_s = tick_cnt_r + TICK_W'(1'b1);
        end
    end

    // State register for debounce, mode, pattern timing and the LED output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_state_r <= 1'b0;
            db_cnt_r   <= {DB_W{1'b0}};
            tick_cnt_r <= {TICK_W{1'b0}};
            phase_r    <= 5'd0;
            mode_r     <= MODE_OFF;
            led_r      <= 1'b0;
        end else begin
            db_state_r <= db_state_s;
            db_cnt_r   <= db_cnt_s;
            tick_cnt_r <= tick_cnt_s;
            phase_r    <= phase_s;
            mode_r     <= mode_s;
            led_r      <= led_s;
        end
    end

    assign led  = led_r;
    assign mode = mode_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer (TICK_DIV=5, DB_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       led;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_err = 0;
    int hi_cnt;

    led_pattern_sequencer #(
        .TICK_DIV  (5),
        .DB_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .led  (led),
        .mode (mode)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a clean press: hold 10 cycles, release 10 cycles.
    task automatic press_hold();
        btn = 1'b1;
        wait_n(10);
        btn = 1'b0;
        wait_n(10);
    endtask

    // Directed scenarios.
    initial begin
        rst = 1'b1;
        btn = 1'b0;
        wait_n(2);
        check_eq("reset_led", 32'(led), 32'd0);
        check_eq("reset_mode", 32'(mode), 32'd0);
        rst = 1'b0;

        // Glitch shorter than the debounce interval must be ignored.
        btn = 1'b1;
        wait_n(3);
        btn = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            wait_n(1);
            if (led) hi_cnt = hi_cnt + 1;
        end
        check_eq("glitch_mode", 32'(mode), 32'd0);
        check_eq("glitch_led_hi_cycles", 32'(hi_cnt), 32'd0);

        // Reset held with button pressed and clock running.
        rst = 1'b1;
        btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_n(2);
            check_eq("rst_hold_led", 32'(led), 32'd0);
            check_eq("rst_hold_mode", 32'(mode), 32'd0);
        end
        rst = 1'b0;
        wait_n(5);
        check_eq("rst_rel_edge4_mode", 32'(mode), 32'd0);
        wait_n(1);
        check_eq("rst_rel_edge5_mode", 32'(mode), 32'd1);
        check_eq("rst_rel_edge5_led", 32'(led), 32'd0);
        wait_n(1);
        check_eq("rst_rel_edge6_led", 32'(led), 32'd1);

        // Asynchronous reset: outputs clear with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_led", 32'(led), 32'd0);
        check_eq("async_rst_mode", 32'(mode), 32'd0);
        wait_n(1);
        btn = 1'b0;
        wait_n(2);
        rst = 1'b0;

        // Four clean presses step OFF->SLOW->FAST->HEARTBEAT->OFF.
        for (int i = 0; i < 4; i++) begin
            btn = 1'b1;
            wait_n(10);
            check_eq("cycle_held_mode", 32'(mode), 32'((i + 1) % 4));
            btn = 1'b0;
            wait_n(10);
            check_eq("cycle_released_mode", 32'(mode), 32'((i + 1) % 4));
        end

        // Enter SLOW, then press into FAST and observe 40 cycles (button kept held).
        press_hold();
        btn = 1'b1;
        wait_n(6);
        check_eq("fast_mode", 32'(mode), 32'd2);
        for (int k = 0; k < 40; k++) begin
            wait_n(1);
            check_eq("fast_led", 32'(led), ((k % 20) < 10) ? 32'd1 : 32'd0);
        end
        check_eq("fast_held_mode", 32'(mode), 32'd2);

        // Release, press into HEARTBEAT and observe 50 cycles.
        btn = 1'b0;
        wait_n(10);
        btn = 1'b1;
        wait_n(6);
        check_eq("heart_mode", 32'(mode), 32'd3);
        for (int k = 0; k < 50; k++) begin
            wait_n(1);
            check_eq("heart_led", 32'(led),
                     ((k < 5) || ((k >= 10) && (k < 15))) ? 32'd1 : 32'd0);
        end
        btn = 1'b0;
        wait_n(10);

        // Press event coinciding with a tick edge while in SLOW.
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;
        btn = 1'b1;
        wait_n(6);
        check_eq("tick_press_slow_mode", 32'(mode), 32'd1);
        btn = 1'b0;
        wait_n(9);
        btn = 1'b1;
        wait_n(5);
        check_eq("tick_press_before_mode", 32'(mode), 32'd1);
        wait_n(1);
        check_eq("tick_press_after_mode", 32'(mode), 32'd2);
        for (int k = 0; k < 10; k++) begin
            wait_n(1);
            check_eq("tick_press_led_on", 32'(led), 32'd1);
        end
        wait_n(1);
        check_eq("tick_press_led_off", 32'(led), 32'd0);
        btn = 1'b0;
        wait_n(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 2700000: clock cycles per pattern tick (100 ms at 27 MHz); legal range >= 2.
REQ-002 Parameter DB_CYCLES, default 270000: cycles the synchronized button must be stable before acceptance (10 ms at 27 MHz); legal range >= 2.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn  input  1  raw push-button level, asynchronous to clk, active-high (pressed = 1).
REQ-006 led  output 1  registered LED drive, 1 = on.
REQ-007 mode output 2  registered current pattern mode.

Function
REQ-008 btn SHALL pass through a 2-flop synchronizer; the second-stage output is btn_s.
REQ-009 Debounce: db_state holds the accepted level; db_cnt SHALL clear whenever btn_s == db_state, and increment while btn_s != db_state.
REQ-010 When btn_s != db_state and db_cnt == DB_CYCLES-1, db_state SHALL take btn_s and db_cnt SHALL clear on the same edge.
REQ-011 A press event SHALL be the edge where db_state goes 0->1; releases (1->0) SHALL have no effect on mode.
REQ-012 On a press event, mode SHALL advance on that same edge: 0->1->2->3->0 (wrap from 3 to 0).
REQ-013 Modes: 0 OFF, 1 SLOW, 2 FAST, 3 HEARTBEAT.
REQ-014 Tick prescaler tick_cnt SHALL count 0..TICK_DIV-1 and wrap; tick is asserted for the one cycle where tick_cnt == TICK_DIV-1.
REQ-015 Phase counter SHALL advance on tick and wrap at the mode period: OFF period 1 (phase held 0), SLOW 20, FAST 4, HEARTBEAT 10.
REQ-016 Pattern: OFF never on; SLOW on for phases 0-9; FAST on for phases 0-1; HEARTBEAT on for phases 0 and 2 only.
REQ-017 led SHALL be registered: led at edge N+1 = pattern(mode, phase) as held after edge N (one-cycle latency).
REQ-018 A press event SHALL clear tick_cnt and phase on the same edge mode advances, so every new mode starts at phase 0 with a full tick interval.
REQ-019 Tick and press on the same edge: press wins; phase = 0, tick_cnt = 0, tick ignored.
REQ-020 Any btn pulse whose synchronized width is shorter than DB_CYCLES cycles SHALL NOT change db_state or mode.
REQ-021 Holding btn indefinitely SHALL produce exactly one mode advance.
REQ-022 Timing: first edge sampling btn = 1 is edge 0; with btn held high and db_state = 0, mode changes at edge DB_CYCLES+1 and led reflects the new mode at edge DB_CYCLES+2.

Reset
REQ-023 rst asserted SHALL immediately (asynchronously) force led = 0, mode = 0, phase = 0, tick_cnt = 0, db_cnt = 0, db_state = 0 and both synchronizer flops = 0.
REQ-024 While rst is high all state SHALL hold reset values regardless of btn or clk.
REQ-025 Reset mid-pattern or mid-debounce SHALL discard all progress; after release a press needs a full new DB_CYCLES stable interval.
REQ-026 First rising clk edge after rst release SHALL begin normal counting from zero; no press event is generated from reset release with btn held high until DB_CYCLES stable cycles elapse.

Verification (TICK_DIV=5, DB_CYCLES=4 for all scenarios)
REQ-027 Reset: rst high with btn = 1 and clk running -> led = 0, mode = 0 throughout; rst deassert with btn held -> mode = 1 at edge 5 after release, led = 1 at edge 6.
REQ-028 Glitch rejection: btn high for 3 cycles, then low -> mode stays 0, led stays 0.
REQ-029 Mode cycle: 4 clean presses (each held 10 cycles, released 10 cycles) -> mode sequence 1, 2, 3, 0; exactly one advance per press.
REQ-030 FAST pattern: mode 2, 40 cycles observed -> led high 10 cycles, low 10 cycles, repeating, first high at press edge + 1.
REQ-031 HEARTBEAT: mode 3, 50 cycles -> led high for cycles 0-4 and 10-14 of period, low otherwise.
REQ-032 Press on tick edge: align press event with tick_cnt == 4 in SLOW -> mode = 2, phase = 0, tick_cnt = 0 after edge, led = 1 for next 10 cycles.
